// File: rtl/vga_pkg.sv
// Shared display geometry and cursor-ownership types for the VGA pipeline.
package vga_pkg;

    localparam int unsigned HOR_PIXELS = 800;
    localparam int unsigned VER_PIXELS = 600;
    localparam int unsigned X_MAX_DEF  = HOR_PIXELS - 1;
    localparam int unsigned Y_MAX_DEF  = VER_PIXELS - 1;

    typedef enum logic {
        OWN_LOC = 1'b0,
        OWN_REM = 1'b1
    } owner_e;

endpackage

// File: rtl/pos_clamp.sv
// Combinational saturation of a 12-bit cursor position to the visible area.
module pos_clamp #(
    parameter int unsigned X_MAX = 799,
    parameter int unsigned Y_MAX = 599
) (
    input  logic [11:0] x_i,
    input  logic [11:0] y_i,
    output logic [11:0] x_o,
    output logic [11:0] y_o
);

    localparam logic [11:0] XLim = 12'(X_MAX);
    localparam logic [11:0] YLim = 12'(Y_MAX);

    assign x_o = (x_i > XLim) ? XLim : x_i;
    assign y_o = (y_i > YLim) ? YLim : y_i;

endmodule

// File: rtl/mouse_arb_ctl.sv
// Arbitrates the cursor between local mouse and remote player; the cursor only
// moves at frame boundaries so the draw stage never sees a mid-frame change.
module mouse_arb_ctl
    import vga_pkg::*;
#(
    parameter int unsigned IDLE_FRAMES = 60,
    parameter int unsigned X_MAX       = X_MAX_DEF,
    parameter int unsigned Y_MAX       = Y_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic [11:0] loc_xpos,
    input  logic [11:0] loc_ypos,
    input  logic        loc_stb,
    input  logic [11:0] rem_xpos,
    input  logic [11:0] rem_ypos,
    input  logic        rem_valid,
    output logic        rem_ready,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        owner,
    output logic        frame_upd
);

    localparam int unsigned IdleW = (IDLE_FRAMES < 1) ? 1 : $clog2(IDLE_FRAMES + 1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_FRAMES);

    owner_e           state_q, state_d;
    logic             vblnk_q, armed_q, armed_d;
    logic [11:0]      loc_x_q, loc_x_d, loc_y_q, loc_y_d;
    logic [11:0]      rem_x_q, rem_x_d, rem_y_q, rem_y_d;
    logic             loc_pend_q, loc_pend_d, rem_pend_q, rem_pend_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [11:0]      xpos_q, xpos_d, ypos_q, ypos_d;
    logic             frame_upd_q, frame_upd_d;

    logic        fe, oth_pend, sw, new_pend, load;
    owner_e      new_state;
    logic [11:0] sel_x, sel_y, clp_x, clp_y;

    assign rem_ready = ~rst;

    // armed_q keeps vblnk held high across reset release from faking a frame edge
    assign fe        = vblnk & ~vblnk_q & armed_q;
    assign armed_d   = armed_q | ~vblnk;
    assign oth_pend  = (state_q == OWN_LOC) ? rem_pend_q : loc_pend_q;
    assign sw        = fe && (idle_q == IdleMax) && oth_pend;
    assign new_state = sw ? ((state_q == OWN_LOC) ? OWN_REM : OWN_LOC) : state_q;
    assign new_pend  = (new_state == OWN_LOC) ? loc_pend_q : rem_pend_q;
    assign load      = fe && new_pend;
    assign sel_x     = (new_state == OWN_LOC) ? loc_x_q : rem_x_q;
    assign sel_y     = (new_state == OWN_LOC) ? loc_y_q : rem_y_q;

    pos_clamp #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_pos_clamp (
        .x_i (sel_x),
        .y_i (sel_y),
        .x_o (clp_x),
        .y_o (clp_y)
    );

    always_comb begin
        state_d     = new_state;
        loc_x_d     = loc_x_q;
        loc_y_d     = loc_y_q;
        rem_x_d     = rem_x_q;
        rem_y_d     = rem_y_q;
        loc_pend_d  = loc_pend_q;
        rem_pend_d  = rem_pend_q;
        idle_d      = idle_q;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        frame_upd_d = 1'b0;

        if (load) begin
            xpos_d      = clp_x;
            ypos_d      = clp_y;
            frame_upd_d = 1'b1;
            idle_d      = '0;
            if (new_state == OWN_LOC) loc_pend_d = 1'b0;
            else                      rem_pend_d = 1'b0;
        end else if (fe && (idle_q != IdleMax)) begin
            idle_d = idle_q + IdleW'(1);
        end

        // Captures win over the flag clear above: fresh data waits for the next edge
        if (loc_stb) begin
            loc_x_d    = loc_xpos;
            loc_y_d    = loc_ypos;
            loc_pend_d = 1'b1;
        end
        if (rem_valid && rem_ready) begin
            rem_x_d    = rem_xpos;
            rem_y_d    = rem_ypos;
            rem_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= OWN_LOC;
            vblnk_q     <= 1'b0;
            armed_q     <= 1'b0;
            loc_x_q     <= '0;
            loc_y_q     <= '0;
            rem_x_q     <= '0;
            rem_y_q     <= '0;
            loc_pend_q  <= 1'b0;
            rem_pend_q  <= 1'b0;
            idle_q      <= '0;
            xpos_q      <= '0;
            ypos_q      <= '0;
            frame_upd_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vblnk_q     <= vblnk;
            armed_q     <= armed_d;
            loc_x_q     <= loc_x_d;
            loc_y_q     <= loc_y_d;
            rem_x_q     <= rem_x_d;
            rem_y_q     <= rem_y_d;
            loc_pend_q  <= loc_pend_d;
            rem_pend_q  <= rem_pend_d;
            idle_q      <= idle_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            frame_upd_q <= frame_upd_d;
        end
    end

    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign owner     = state_q;
    assign frame_upd = frame_upd_q;

endmodule

// File: tb/tb_mouse_arb_ctl.sv
// Directed self-checking bench for the cursor ownership arbiter.
module tb_mouse_arb_ctl;

    logic        clk = 1'b0;
    logic        rst, vblnk, loc_stb, rem_valid;
    logic [11:0] loc_xpos, loc_ypos, rem_xpos, rem_ypos;
    logic        rem_ready, owner, frame_upd;
    logic [11:0] xpos, ypos;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mouse_arb_ctl #(
        .IDLE_FRAMES (60),
        .X_MAX       (799),
        .Y_MAX       (599)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vblnk     (vblnk),
        .loc_xpos  (loc_xpos),
        .loc_ypos  (loc_ypos),
        .loc_stb   (loc_stb),
        .rem_xpos  (rem_xpos),
        .rem_ypos  (rem_ypos),
        .rem_valid (rem_valid),
        .rem_ready (rem_ready),
        .xpos      (xpos),
        .ypos      (ypos),
        .owner     (owner),
        .frame_upd (frame_upd)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Silent frames: one rising and one falling vblnk each.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vblnk = 1'b1; step();
            vblnk = 1'b0; step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step();
        rst = 1'b0; step();
    endtask

    initial begin
        rst = 1'b1; vblnk = 1'b0; loc_stb = 1'b0; rem_valid = 1'b0;
        loc_xpos = '0; loc_ypos = '0; rem_xpos = '0; rem_ypos = '0;
        step(); step();
        chk("rst_xpos", 32'(xpos), 0);
        chk("rst_ypos", 32'(ypos), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_upd", 32'(frame_upd), 0);
        chk("rst_ready", 32'(rem_ready), 0);
        rst = 1'b0; step();
        chk("ready_after_rst", 32'(rem_ready), 1);

        // Basic local update.
        loc_xpos = 12'd100; loc_ypos = 12'd200; loc_stb = 1'b1; step();
        loc_stb = 1'b0; step();
        chk("pre_fe_xpos", 32'(xpos), 0);
        vblnk = 1'b1; step();
        chk("loc_xpos", 32'(xpos), 100);
        chk("loc_ypos", 32'(ypos), 200);
        chk("loc_upd", 32'(frame_upd), 1);
        chk("loc_owner", 32'(owner), 0);
        vblnk = 1'b0; step();
        chk("upd_one_cycle", 32'(frame_upd), 0);
        chk("hold_xpos", 32'(xpos), 100);

        // Clamp both axes.
        loc_xpos = 12'd1000; loc_ypos = 12'd4000; loc_stb = 1'b1; step();
        loc_stb = 1'b0;
        vblnk = 1'b1; step();
        chk("clamp_x", 32'(xpos), 799);
        chk("clamp_y", 32'(ypos), 599);
        vblnk = 1'b0; step();

        // Capture in the frame-edge cycle is deferred to the next edge.
        loc_xpos = 12'd50; loc_ypos = 12'd60; loc_stb = 1'b1; vblnk = 1'b1; step();
        loc_stb = 1'b0;
        chk("defer_no_upd", 32'(frame_upd), 0);
        chk("defer_hold_x", 32'(xpos), 799);
        vblnk = 1'b0; step();
        vblnk = 1'b1; step();
        chk("defer_x", 32'(xpos), 50);
        chk("defer_y", 32'(ypos), 60);
        chk("defer_upd", 32'(frame_upd), 1);
        vblnk = 1'b0; step();

        // Remote takes over on the 61st idle frame edge.
        do_reset();
        rem_xpos = 12'd300; rem_ypos = 12'd300; rem_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            vblnk = 1'b1; step();
            chk("idle_xpos", 32'(xpos), 0);
            chk("idle_owner", 32'(owner), 0);
            vblnk = 1'b0; step();
        end
        vblnk = 1'b1; step();
        chk("sw_owner", 32'(owner), 1);
        chk("sw_xpos", 32'(xpos), 300);
        chk("sw_ypos", 32'(ypos), 300);
        chk("sw_upd", 32'(frame_upd), 1);
        vblnk = 1'b0; rem_valid = 1'b0; step();

        // Simultaneous captures: local applied, remote retained (latest wins).
        do_reset();
        loc_xpos = 12'd10; loc_ypos = 12'd20; loc_stb = 1'b1;
        rem_xpos = 12'd400; rem_ypos = 12'd500; rem_valid = 1'b1;
        #1;
        chk("both_ready", 32'(rem_ready), 1);
        step();
        loc_stb = 1'b0; rem_valid = 1'b0;
        vblnk = 1'b1; step();
        chk("both_loc_x", 32'(xpos), 10);
        chk("both_loc_y", 32'(ypos), 20);
        chk("both_owner", 32'(owner), 0);
        vblnk = 1'b0; step();
        rem_xpos = 12'd410; rem_ypos = 12'd510; rem_valid = 1'b1; step();
        rem_valid = 1'b0;
        frames(60);
        chk("retain_pre_owner", 32'(owner), 0);
        vblnk = 1'b1; step();
        chk("retain_owner", 32'(owner), 1);
        chk("retain_x", 32'(xpos), 410);
        chk("retain_y", 32'(ypos), 510);
        vblnk = 1'b0; step();

        // Reset while remote owns with pending data discards everything.
        rem_xpos = 12'd5; rem_ypos = 12'd5; rem_valid = 1'b1; step();
        rem_valid = 1'b0;
        rst = 1'b1; step();
        chk("rst2_owner", 32'(owner), 0);
        chk("rst2_xpos", 32'(xpos), 0);
        chk("rst2_ypos", 32'(ypos), 0);
        chk("rst2_ready", 32'(rem_ready), 0);
        rst = 1'b0; step();
        vblnk = 1'b1; step();
        chk("rst2_no_upd", 32'(frame_upd), 0);
        chk("rst2_fe_x", 32'(xpos), 0);
        vblnk = 1'b0; step();

        // vblnk held high through reset release is not a frame edge.
        vblnk = 1'b1; rst = 1'b1; step();
        rst = 1'b0; step();
        loc_xpos = 12'd7; loc_ypos = 12'd8; loc_stb = 1'b1; step();
        loc_stb = 1'b0; step(); step();
        chk("held_no_upd_x", 32'(xpos), 0);
        vblnk = 1'b0; step();
        vblnk = 1'b1; step();
        chk("real_fe_x", 32'(xpos), 7);
        chk("real_fe_y", 32'(ypos), 8);
        chk("real_fe_upd", 32'(frame_upd), 1);
        vblnk = 1'b0; step();
        vblnk = 1'b1; step();
        chk("no_strobe_no_upd", 32'(frame_upd), 0);
        vblnk = 1'b0; step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
